aes_ila_multi_instr: RTL and testbench
======================================

// Module: aes_ila_multi_instr
// PURPOSE
//  Parametrised multi-instruction ILA model of the AES accelerator register interface.
//  Decodes byte writes on addr/data_in/stb/wr into five instructions and updates the architectural state.
//  Instructions: key, counter, operation address, operation length, and operation start.
//  START_OP runs a multi-cycle block-processing FSM.
//  Keeps a per-instruction saturating step counter for property checking.
//  Sits beside the RTL in the equivalence/property harness, in place of single-instruction models.
// PARAMETERS
//  ADDR_W     16        address width
//  DATA_W     8         write-data width (one byte lane)
//  BLK_W      128       width of key0, ctr, aes_out
//  LEN_W      16        width of opaddr, oplen, uaes_ctr
//  CNT_W      8         width of each step counter
//  BASE_ADDR  16'hff00  base of AES register window
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           synchronous, active-high reset
//  start         in   1           harness start qualifier
//  addr          in   ADDR_W      register address
//  data_in       in   DATA_W      write byte
//  stb           in   1           bus strobe
//  wr            in   1           write enable
//  ila_valid     out  1           start && !busy
//  ila_decode    out  5           one-hot {START_OP,WR_OPLEN,WR_OPADDR,WR_CTR,WR_KEY0}
//  busy          out  1           START_OP FSM running
//  key0          out  BLK_W       key register
//  ctr           out  BLK_W       counter register
//  opaddr        out  LEN_W       operation address
//  oplen         out  LEN_W       operation length, bytes
//  uaes_ctr      out  LEN_W       bytes processed in current operation
//  aes_out       out  BLK_W       accumulated output block
//  step_cnt      out  5*CNT_W     packed per-instruction counters, index = ila_decode bit
// BEHAVIOUR
//  Clocking and reset: one clock; reset is synchronous and active-high; rst has priority over everything.
//  Reset values: all registers and outputs 0; FSM to IDLE.
//  Decode: combinational, qualified by ila_valid && stb && wr. Offsets are addr-BASE_ADDR.
//    WR_KEY0    offset 0x10-0x1F: key0 byte[offset[3:0]] <= data_in
//    WR_CTR     offset 0x20-0x2F: ctr byte[offset[3:0]] <= data_in
//    WR_OPADDR  offset 0x02/0x03: opaddr low/high byte
//    WR_OPLEN   offset 0x04/0x05: oplen low/high byte
//    START_OP   offset 0x00 with data_in[0]=1
//  Unmapped address, read, or data_in[0]=0 at offset 0x00: ila_decode=0, no state change.
//  All updates land 1 cycle after the decoding edge. Untouched state holds its value.
//  FSM states: IDLE, RUN.
//    IDLE, START_OP: uaes_ctr<=0, aes_out held; go to RUN if oplen!=0, else stay IDLE.
//    RUN, each cycle:
//      aes_out <= aes_out ^ key0 ^ (ctr + uaes_ctr[LEN_W-1:4]), mod 2^BLK_W;
//      uaes_ctr <= uaes_ctr+16.
//    RUN exit: go to IDLE on the cycle where uaes_ctr+16 >= oplen.
//    Block count is ceil(oplen/16). busy=(state==RUN).
//  During RUN: ila_valid=0; all writes ignored; key0/ctr/opaddr/oplen frozen.
//  Step counters, per instruction i:
//    on decode of i, step_cnt[i] <= 1;
//    else if 1 <= step_cnt[i] < 2^CNT_W-1, increment;
//    saturates at 2^CNT_W-1; 0 stays 0.
//  At most one instruction decodes per cycle (addr-exclusive).
//  Wrap: uaes_ctr+16 is evaluated in LEN_W+1 bits, so oplen near 2^LEN_W terminates.
//  Reset mid-RUN aborts: registers cleared, FSM to IDLE the next cycle.
// CONFIGURATION
//  AES_ILA_RANDINIT_EN
//    defined: adds inputs <reg>_randinit (one per state register, same width), loaded on rst.
//      Applies to key0, ctr, opaddr, oplen, uaes_ctr, aes_out.
//      step_cnt and FSM still reset to 0 and IDLE.
//    undefined: no extra ports; all reset to 0.
// TESTING
//  Key write: write 0xA5 to BASE+0x13 -> key0 = 0xA5<<24; step_cnt[0]=1, then 2,3.
//  Len/start:
//    write oplen=0x0030, then START_OP with key0=0, ctr=1 -> busy for 3 cycles.
//    Then uaes_ctr=0x30 and aes_out=1^2^3=0; ila_valid=0 throughout.
//  oplen=0 START_OP -> no busy cycle; uaes_ctr=0; step_cnt[4]=1.
//  Write during RUN to BASE+0x20 -> ctr unchanged, ila_decode=0.
//  Unmapped write to BASE+0x40 -> no state change; data_in=0 at BASE+0x00 -> no start.
//  rst asserted mid-RUN -> next cycle busy=0 and all outputs 0.
//  Idle 300 cycles after decode -> step counter holds 255.

Source files
------------

// File: rtl/aes_ila_multi_instr.sv
// aes_ila_multi_instr: multi-instruction ILA model of the AES accelerator register window.
// Define AES_ILA_RANDINIT_EN to load state registers from <reg>_randinit inputs on reset.
module aes_ila_multi_instr #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int BLK_W = 128,
   parameter int LEN_W = 16,
   parameter int CNT_W = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hff00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              stb,
   input  logic              wr,
`ifdef AES_ILA_RANDINIT_EN
   input  logic [BLK_W-1:0]  key0_randinit,
   input  logic [BLK_W-1:0]  ctr_randinit,
   input  logic [LEN_W-1:0]  opaddr_randinit,
   input  logic [LEN_W-1:0]  oplen_randinit,
   input  logic [LEN_W-1:0]  uaes_ctr_randinit,
   input  logic [BLK_W-1:0]  aes_out_randinit,
`endif
   output logic              ila_valid,
   output logic [4:0]        ila_decode,
   output logic              busy,
   output logic [BLK_W-1:0]  key0,
   output logic [BLK_W-1:0]  ctr,
   output logic [LEN_W-1:0]  opaddr,
   output logic [LEN_W-1:0]  oplen,
   output logic [LEN_W-1:0]  uaes_ctr,
   output logic [BLK_W-1:0]  aes_out,
   output logic [5*CNT_W-1:0] step_cnt
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   state_t state_q, state_d;
   logic [BLK_W-1:0] key0_q, key0_d, ctr_q, ctr_d, aes_out_q, aes_out_d;
   logic [LEN_W-1:0] opaddr_q, opaddr_d, oplen_q, oplen_d, uaes_ctr_q, uaes_ctr_d;
   logic [5*CNT_W-1:0] step_q, step_d;
   logic [ADDR_W-1:0] off;
   logic wen;
   logic [LEN_W:0] nxt;
   assign busy = state_q == RUN;
   assign ila_valid = start && !busy;
   assign key0 = key0_q;
   assign ctr = ctr_q;
   assign opaddr = opaddr_q;
   assign oplen = oplen_q;
   assign uaes_ctr = uaes_ctr_q;
   assign aes_out = aes_out_q;
   assign step_cnt = step_q;
   always_comb begin
      off = addr - BASE_ADDR;
      wen = ila_valid && stb && wr;
      ila_decode[0] = wen && off[ADDR_W-1:4] == (ADDR_W-4)'(1);
      ila_decode[1] = wen && off[ADDR_W-1:4] == (ADDR_W-4)'(2);
      ila_decode[2] = wen && off[ADDR_W-1:1] == (ADDR_W-1)'(1);
      ila_decode[3] = wen && off[ADDR_W-1:1] == (ADDR_W-1)'(2);
      ila_decode[4] = wen && off == '0 && data_in[0];
   end
   always_comb begin
      key0_d = key0_q;
      ctr_d = ctr_q;
      opaddr_d = opaddr_q;
      oplen_d = oplen_q;
      uaes_ctr_d = uaes_ctr_q;
      aes_out_d = aes_out_q;
      state_d = state_q;
      // 17-bit sum so an oplen near the top of the range still reaches the exit compare
      nxt = {1'b0, uaes_ctr_q} + (LEN_W+1)'(16);
      if (ila_decode[0]) key0_d[32'(off[3:0])*DATA_W +: DATA_W] = data_in;
      if (ila_decode[1]) ctr_d[32'(off[3:0])*DATA_W +: DATA_W] = data_in;
      if (ila_decode[2]) opaddr_d[32'(off[0])*DATA_W +: DATA_W] = data_in;
      if (ila_decode[3]) oplen_d[32'(off[0])*DATA_W +: DATA_W] = data_in;
      if (ila_decode[4]) begin
         uaes_ctr_d = '0;
         state_d = oplen_q != '0 ? RUN : IDLE;
      end
      if (state_q == RUN) begin
         aes_out_d = aes_out_q ^ key0_q ^ (ctr_q + BLK_W'(uaes_ctr_q[LEN_W-1:4]));
         uaes_ctr_d = nxt[LEN_W-1:0];
         state_d = nxt >= {1'b0, oplen_q} ? IDLE : RUN;
      end
      for (int i = 0; i < 5; i++)
         step_d[i*CNT_W +: CNT_W] = ila_decode[i] ? CNT_W'(1) :
            (step_q[i*CNT_W +: CNT_W] != '0 && step_q[i*CNT_W +: CNT_W] != CNT_MAX) ?
            step_q[i*CNT_W +: CNT_W] + CNT_W'(1) : step_q[i*CNT_W +: CNT_W];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
`ifdef AES_ILA_RANDINIT_EN
         key0_q <= key0_randinit;
         ctr_q <= ctr_randinit;
         opaddr_q <= opaddr_randinit;
         oplen_q <= oplen_randinit;
         uaes_ctr_q <= uaes_ctr_randinit;
         aes_out_q <= aes_out_randinit;
`else
         key0_q <= '0;
         ctr_q <= '0;
         opaddr_q <= '0;
         oplen_q <= '0;
         uaes_ctr_q <= '0;
         aes_out_q <= '0;
`endif
         step_q <= '0;
         state_q <= IDLE;
      end else begin
         key0_q <= key0_d;
         ctr_q <= ctr_d;
         opaddr_q <= opaddr_d;
         oplen_q <= oplen_d;
         uaes_ctr_q <= uaes_ctr_d;
         aes_out_q <= aes_out_d;
         step_q <= step_d;
         state_q <= state_d;
      end
   end
endmodule

// File: tb/tb_aes_ila_multi_instr.sv
// tb_aes_ila_multi_instr: directed self-checking bench for aes_ila_multi_instr.
module tb_aes_ila_multi_instr;
   logic clk = 0, rst = 1, start = 1, stb = 0, wr = 0;
   logic [15:0] addr = '0;
   logic [7:0] data_in = '0;
   logic ila_valid, busy;
   logic [4:0] ila_decode;
   logic [127:0] key0, ctr, aes_out;
   logic [15:0] opaddr, oplen, uaes_ctr;
   logic [39:0] step_cnt;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   aes_ila_multi_instr dut (
      .clk(clk), .rst(rst), .start(start), .addr(addr), .data_in(data_in), .stb(stb), .wr(wr),
      .ila_valid(ila_valid), .ila_decode(ila_decode), .busy(busy), .key0(key0), .ctr(ctr),
      .opaddr(opaddr), .oplen(oplen), .uaes_ctr(uaes_ctr), .aes_out(aes_out), .step_cnt(step_cnt)
   );
   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      addr = a; data_in = d; stb = 1; wr = 1;
      @(posedge clk); #1;
      stb = 0; wr = 0;
   endtask
   task automatic run_count(output int n);
      n = 0;
      while (busy && n < 5000) begin
         if (ila_valid !== 1'b0) begin
            errors++; $display("FAIL valid_in_run: got %b want 0", ila_valid);
         end
         checks++;
         n++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_reset;
      rst = 1;
      repeat (2) @(posedge clk);
      #1; rst = 0;
      checks++;
      if ({busy, key0, ctr, opaddr, oplen, uaes_ctr, aes_out, step_cnt} !== '0) begin
         errors++; $display("FAIL reset_state: busy=%b key0=%h ctr=%h aes_out=%h step=%h", busy, key0, ctr, aes_out, step_cnt);
      end
      checks++;
      if (ila_valid !== 1'b1) begin errors++; $display("FAIL reset_valid: got %b want 1", ila_valid); end
   endtask
   task automatic test_key;
      addr = 16'hff13; data_in = 8'ha5; stb = 1; wr = 1; #1;
      checks++;
      if (ila_decode !== 5'b00001) begin errors++; $display("FAIL key_decode: got %b want 00001", ila_decode); end
      @(posedge clk); #1; stb = 0; wr = 0;
      checks++;
      if (key0 !== 128'ha500_0000) begin errors++; $display("FAIL key_value: got %h want a5000000", key0); end
      for (int k = 1; k <= 3; k++) begin
         checks++;
         if (step_cnt[7:0] !== 8'(k)) begin errors++; $display("FAIL key_step: got %0d want %0d", step_cnt[7:0], k); end
         @(posedge clk); #1;
      end
   endtask
   task automatic test_ctr_opaddr;
      addr = 16'hff20; data_in = 8'h01; stb = 1; wr = 1; #1;
      checks++;
      if (ila_decode !== 5'b00010) begin errors++; $display("FAIL ctr_decode: got %b want 00010", ila_decode); end
      @(posedge clk); #1; stb = 0; wr = 0;
      checks++;
      if (ctr !== 128'h1) begin errors++; $display("FAIL ctr_value: got %h want 1", ctr); end
      bus_write(16'hff02, 8'h34);
      bus_write(16'hff03, 8'h12);
      checks++;
      if (opaddr !== 16'h1234) begin errors++; $display("FAIL opaddr: got %h want 1234", opaddr); end
      checks++;
      if (step_cnt[23:16] !== 8'd1) begin errors++; $display("FAIL opaddr_step: got %0d want 1", step_cnt[23:16]); end
   endtask
   task automatic test_len_start;
      int n;
      bus_write(16'hff13, 8'h00);
      bus_write(16'hff04, 8'h30);
      bus_write(16'hff05, 8'h00);
      checks++;
      if (oplen !== 16'h0030 || key0 !== '0) begin errors++; $display("FAIL oplen: got %h key0=%h want 0030/0", oplen, key0); end
      addr = 16'hff00; data_in = 8'h01; stb = 1; wr = 1; #1;
      checks++;
      if (ila_decode !== 5'b10000) begin errors++; $display("FAIL start_decode: got %b want 10000", ila_decode); end
      @(posedge clk); #1; stb = 0; wr = 0;
      run_count(n);
      checks++;
      if (n !== 3) begin errors++; $display("FAIL busy_cycles: got %0d want 3", n); end
      checks++;
      if (uaes_ctr !== 16'h30 || aes_out !== '0) begin errors++; $display("FAIL run_result: uaes=%h aes=%h want 30/0", uaes_ctr, aes_out); end
      checks++;
      if (step_cnt[39:32] !== 8'd4) begin errors++; $display("FAIL start_step: got %0d want 4", step_cnt[39:32]); end
   endtask
   task automatic test_write_during_run;
      int n;
      bus_write(16'hff00, 8'h01);
      addr = 16'hff20; data_in = 8'h55; stb = 1; wr = 1; #1;
      checks++;
      if (ila_decode !== 5'b0 || ila_valid !== 1'b0) begin errors++; $display("FAIL run_decode: got %b valid=%b want 0/0", ila_decode, ila_valid); end
      @(posedge clk); #1; stb = 0; wr = 0;
      run_count(n);
      checks++;
      if (ctr !== 128'h1 || n !== 2) begin errors++; $display("FAIL run_write: ctr=%h rest=%0d want 1/2", ctr, n); end
   endtask
   task automatic test_partial_block;
      int n;
      bus_write(16'hff10, 8'h0f);
      bus_write(16'hff04, 8'h11);
      bus_write(16'hff00, 8'h01);
      run_count(n);
      checks++;
      if (n !== 2 || uaes_ctr !== 16'h20 || aes_out !== 128'h3) begin
         errors++; $display("FAIL partial_block: cycles=%0d uaes=%h aes=%h want 2/20/3", n, uaes_ctr, aes_out);
      end
   endtask
   task automatic test_zero_len;
      bus_write(16'hff04, 8'h00);
      bus_write(16'hff00, 8'h01);
      checks++;
      if (busy !== 1'b0 || uaes_ctr !== '0 || step_cnt[39:32] !== 8'd1) begin
         errors++; $display("FAIL zero_len: busy=%b uaes=%h step=%0d want 0/0/1", busy, uaes_ctr, step_cnt[39:32]);
      end
   endtask
   task automatic test_unmapped;
      addr = 16'hff40; data_in = 8'hff; stb = 1; wr = 1; #1;
      checks++;
      if (ila_decode !== 5'b0) begin errors++; $display("FAIL unmapped_decode: got %b want 0", ila_decode); end
      addr = 16'hff00; data_in = 8'h00; #1;
      checks++;
      if (ila_decode !== 5'b0) begin errors++; $display("FAIL nostart_decode: got %b want 0", ila_decode); end
      @(posedge clk); #1; stb = 0; wr = 0;
      checks++;
      if (busy !== 1'b0 || key0 !== 128'h0f || ctr !== 128'h1 || opaddr !== 16'h1234 || oplen !== 16'h0) begin
         errors++; $display("FAIL unmapped_state: busy=%b key0=%h ctr=%h opaddr=%h oplen=%h", busy, key0, ctr, opaddr, oplen);
      end
   endtask
   task automatic test_wrap;
      int n;
      bus_write(16'hff04, 8'hff);
      bus_write(16'hff05, 8'hff);
      bus_write(16'hff00, 8'h01);
      run_count(n);
      checks++;
      if (n !== 4096 || uaes_ctr !== 16'h0) begin errors++; $display("FAIL wrap: cycles=%0d uaes=%h want 4096/0", n, uaes_ctr); end
   endtask
   task automatic test_reset_mid_run;
      bus_write(16'hff05, 8'h00);
      bus_write(16'hff04, 8'h30);
      bus_write(16'hff00, 8'h01);
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL pre_abort_busy: got %b want 1", busy); end
      rst = 1;
      @(posedge clk); #1; rst = 0;
      checks++;
      if ({busy, key0, ctr, opaddr, oplen, uaes_ctr, aes_out, step_cnt} !== '0) begin
         errors++; $display("FAIL abort_state: busy=%b key0=%h ctr=%h uaes=%h aes=%h step=%h", busy, key0, ctr, uaes_ctr, aes_out, step_cnt);
      end
   endtask
   task automatic test_saturate;
      bus_write(16'hff13, 8'ha5);
      repeat (300) @(posedge clk);
      #1;
      checks++;
      if (step_cnt[7:0] !== 8'd255) begin errors++; $display("FAIL saturate: got %0d want 255", step_cnt[7:0]); end
      checks++;
      if (step_cnt[15:8] !== 8'd0) begin errors++; $display("FAIL zero_hold: got %0d want 0", step_cnt[15:8]); end
   endtask
   initial begin
      test_reset;
      test_key;
      test_ctr_opaddr;
      test_len_start;
      test_write_during_run;
      test_partial_block;
      test_zero_len;
      test_unmapped;
      test_wrap;
      test_reset_mid_run;
      test_saturate;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
